// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port instruction/data RAM between the
// fetch stage (read-only) and the memory stage (load/store). Accesses are
// serialized, the RAM address/strobe are held for RAM_LAT cycles, and the
// combinational stall outputs freeze the pipeline while a requester waits.
// The memory stage wins conflicts because it holds the older instruction.
// Optional build macro MEMARB_ANTISTARVE_EN adds a saturating counter that
// hands one conflict to fetch after STARVE_MAX consecutive fetch losses.
module mem_port_arbiter #(
    parameter int unsigned RAM_LAT    = 1,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_grant,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_grant,
    output logic              mem_valid,
    output logic [31:0]       mem_rdata,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wre,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [3:0] LAT_INIT = 4'(RAM_LAT - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;          // 0 = fetch, 1 = memory stage
    logic [3:0]        lat_q, lat_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wre_q, ram_wre_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic              if_grant_q, if_grant_d;
    logic              mem_grant_q, mem_grant_d;
    logic              if_valid_q, if_valid_d;
    logic              mem_valid_q, mem_valid_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              starve_hit_s;
    logic              if_wins_s;
    logic              mem_wins_s;

`ifdef MEMARB_ANTISTARVE_EN
    localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

    logic [1:0] starve_q, starve_d;

    assign starve_hit_s = (starve_q == STARVE_LIM);

    // Starvation counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_q <= 2'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Count fetch losses on conflict edges; any fetch grant clears the count.
    always_comb begin
        starve_d = starve_q;
        if ((state_q == ST_IDLE) && if_wins_s) begin
            starve_d = 2'd0;
        end else if ((state_q == ST_IDLE) && mem_wins_s && if_req && (starve_q != 2'b11)) begin
            starve_d = starve_q + 2'd1;
        end else begin
            starve_d = starve_q;
        end
    end
`else
    assign starve_hit_s = 1'b0;
`endif

    assign if_wins_s  = if_req & (~mem_req | starve_hit_s);
    assign mem_wins_s = mem_req & ~if_wins_s;

    // State, latched access and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            lat_q       <= 4'd0;
            ram_addr_q  <= '0;
            ram_wre_q   <= 1'b1;
            ram_wdata_q <= 32'd0;
            if_grant_q  <= 1'b0;
            mem_grant_q <= 1'b0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lat_q       <= lat_d;
            ram_addr_q  <= ram_addr_d;
            ram_wre_q   <= ram_wre_d;
            ram_wdata_q <= ram_wdata_d;
            if_grant_q  <= if_grant_d;
            mem_grant_q <= mem_grant_d;
            if_valid_q  <= if_valid_d;
            mem_valid_q <= mem_valid_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Arbitrate in IDLE, hold the RAM access for RAM_LAT cycles, then complete.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_d       = lat_q;
        ram_addr_d  = ram_addr_q;
        ram_wre_d   = ram_wre_q;
        ram_wdata_d = ram_wdata_q;
        if_grant_d  = 1'b0;
        mem_grant_d = 1'b0;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_wins_s) begin
                    state_d     = ST_ACCESS;
                    owner_d     = 1'b1;
                    lat_d       = LAT_INIT;
                    ram_addr_d  = mem_addr;
                    ram_wre_d   = ~mem_we;
                    ram_wdata_d = mem_wdata;
                    mem_grant_d = 1'b1;
                end else if (if_wins_s) begin
                    state_d     = ST_ACCESS;
                    owner_d     = 1'b0;
                    lat_d       = LAT_INIT;
                    ram_addr_d  = if_addr;
                    ram_wre_d   = 1'b1;
                    ram_wdata_d = 32'd0;
                    if_grant_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (lat_q == 4'd0) begin
                    state_d     = ST_IDLE;
                    ram_addr_d  = '0;
                    ram_wre_d   = 1'b1;
                    ram_wdata_d = 32'd0;
                    if (owner_q) begin
                        mem_valid_d = 1'b1;
                        if (ram_wre_q) begin
                            mem_rdata_d = ram_rdata;
                        end else begin
                            mem_rdata_d = mem_rdata_q;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = ram_rdata;
                    end
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                ram_addr_d  = '0;
                ram_wre_d   = 1'b1;
                ram_wdata_d = 32'd0;
            end
        endcase
    end

    assign if_grant  = if_grant_q;
    assign mem_grant = mem_grant_q;
    assign if_valid  = if_valid_q;
    assign mem_valid = mem_valid_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wre   = ram_wre_q;
    assign ram_wdata = ram_wdata_q;
    assign if_stall  = if_req & ~if_valid_q;
    assign mem_stall = mem_req & ~mem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized transactions against a
// transaction-level reference (expected RAM contents plus expected grant and
// completion timing). The bench also models the RAM: a write commits when the
// strobe returns high and is dropped if reset arrives first.
module tb_mem_port_arbiter;

    localparam int LAT = 3;
    localparam int AW  = 7;

    logic          clock;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_grant;
    logic          if_valid;
    logic [31:0]   if_rdata;
    logic          if_stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_grant;
    logic          mem_valid;
    logic [31:0]   mem_rdata;
    logic          mem_stall;
    logic [AW-1:0] ram_addr;
    logic          ram_wre;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic [31:0]   ram_mem [128];
    logic [31:0]   ref_mem [128];
    logic          ram_load;
    logic          pend;
    logic [AW-1:0] pend_addr;
    logic [31:0]   pend_data;
    logic [31:0]   exp_if_rd;
    logic [31:0]   exp_mem_rd;
    int            checks;
    int            failures;

    mem_port_arbiter #(.RAM_LAT(LAT), .ADDR_W(AW), .STARVE_MAX(3)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant),
        .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_grant(mem_grant), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .ram_addr(ram_addr), .ram_wre(ram_wre), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'h1234_5678;
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    assign ram_rdata = ram_mem[ram_addr];

    // RAM model: write commits at the end of the strobe, reset aborts it.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend <= 1'b0;
            if (ram_load) begin
                for (int i = 0; i < 128; i++) ram_mem[i] <= init_word(i);
            end
        end else if (!ram_wre) begin
            pend      <= 1'b1;
            pend_addr <= ram_addr;
            pend_data <= ram_wdata;
        end else if (pend) begin
            ram_mem[pend_addr] <= pend_data;
            pend               <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // One uncontended access from an idle arbiter: grant next cycle, RAM held
    // for LAT cycles, completion pulse LAT cycles after the grant.
    task automatic do_txn(input bit is_mem, input bit we, input logic [AW-1:0] addr,
                          input logic [31:0] wd);
        bit store;
        store = is_mem & we;
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        tick();
        check("grant_own",   {31'd0, (is_mem ? mem_grant : if_grant)}, 32'd1);
        check("grant_other", {31'd0, (is_mem ? if_grant : mem_grant)}, 32'd0);
        check("stall_wait",  {31'd0, (is_mem ? mem_stall : if_stall)}, 32'd1);
        if_req  = 1'b0;
        mem_req = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            if (k > 0) tick();
            check("acc_addr", {25'd0, ram_addr}, {25'd0, addr});
            check("acc_wre",  {31'd0, ram_wre}, {31'd0, ~store});
            if (store) check("acc_wdata", ram_wdata, wd);
            check("acc_novalid", {31'd0, (if_valid | mem_valid)}, 32'd0);
        end
        tick();
        check("valid_own",   {31'd0, (is_mem ? mem_valid : if_valid)}, 32'd1);
        check("valid_other", {31'd0, (is_mem ? if_valid : mem_valid)}, 32'd0);
        if (is_mem) begin
            if (we) ref_mem[addr] = wd;
            else    exp_mem_rd    = ref_mem[addr];
        end else begin
            exp_if_rd = ref_mem[addr];
        end
        check("mem_rdata", mem_rdata, exp_mem_rd);
        check("if_rdata",  if_rdata,  exp_if_rd);
        check("idle_wre",  {31'd0, ram_wre}, 32'd1);
        check("idle_addr", {25'd0, ram_addr}, 32'd0);
        tick();
        check("valid_pulse", {31'd0, (if_valid | mem_valid)}, 32'd0);
    endtask

    initial begin
        int ng;
        int last;
        int cyc;
        bit exp_is_if;
        checks     = 0;
        failures   = 0;
        exp_if_rd  = 32'd0;
        exp_mem_rd = 32'd0;
        reset      = 1'b0;
        ram_load   = 1'b1;
        if_req     = 1'b0;
        if_addr    = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 32'd0;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
        repeat (3) tick();

        // Reset state
        check("rst_wre",       {31'd0, ram_wre}, 32'd1);
        check("rst_addr",      {25'd0, ram_addr}, 32'd0);
        check("rst_wdata",     ram_wdata, 32'd0);
        check("rst_grants",    {30'd0, if_grant, mem_grant}, 32'd0);
        check("rst_valids",    {30'd0, if_valid, mem_valid}, 32'd0);
        check("rst_if_rdata",  if_rdata, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        ram_load = 1'b0;
        reset    = 1'b1;
        tick();

        // Fetch of preloaded word, store then fetch of the same word
        do_txn(1'b0, 1'b0, 7'd5, 32'd0);
        do_txn(1'b1, 1'b1, 7'd9, 32'hDEAD_BEEF);
        do_txn(1'b0, 1'b0, 7'd9, 32'd0);

        // Simultaneous requests: memory stage first, fetch right after
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 7'd2;
        if_req  = 1'b1; if_addr = 7'd3;
        tick();
        check("cf_mem_grant", {31'd0, mem_grant}, 32'd1);
        check("cf_if_nogrant", {31'd0, if_grant}, 32'd0);
        check("cf_if_stall", {31'd0, if_stall}, 32'd1);
        mem_req = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            if (k > 0) tick();
            check("cf_stall_acc", {31'd0, if_stall}, 32'd1);
            check("cf_if_wait", {31'd0, if_grant}, 32'd0);
        end
        tick();
        exp_mem_rd = ref_mem[2];
        check("cf_mem_valid", {31'd0, mem_valid}, 32'd1);
        check("cf_mem_rdata", mem_rdata, exp_mem_rd);
        check("cf_stall_vld", {31'd0, if_stall}, 32'd1);
        tick();
        check("cf_if_grant", {31'd0, if_grant}, 32'd1);
        if_req = 1'b0;
        repeat (LAT) tick();
        exp_if_rd = ref_mem[3];
        check("cf_if_valid", {31'd0, if_valid}, 32'd1);
        check("cf_if_rdata", if_rdata, exp_if_rd);
        tick();

        // Randomized single-requester traffic with idle gaps
        for (int n = 0; n < 20; n++) begin
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   7'($urandom_range(0, 127)), $urandom);
            repeat ($urandom_range(0, 2)) begin
                tick();
                check("gap_nogrant", {30'd0, if_grant, mem_grant}, 32'd0);
            end
        end

        // Both requests held continuously: grant order and spacing
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 7'd10;
        if_req  = 1'b1; if_addr = 7'd11;
        ng   = 0;
        last = -1;
        cyc  = 0;
        while (ng < 8 && cyc < 200) begin
            tick();
            cyc++;
            if (mem_grant || if_grant) begin
`ifdef MEMARB_ANTISTARVE_EN
                exp_is_if = ((ng % 4) == 3);
`else
                exp_is_if = 1'b0;
`endif
                check("sv_if_grant", {31'd0, if_grant}, {31'd0, exp_is_if});
                check("sv_mem_grant", {31'd0, mem_grant}, {31'd0, ~exp_is_if});
                if (last >= 0) check("sv_gap", cyc - last, LAT + 1);
                last = cyc;
                ng++;
            end
        end
        check("sv_count", ng, 8);
        mem_req = 1'b0;
        if_req  = 1'b0;
        repeat (LAT + 2) tick();
        exp_mem_rd = ref_mem[10];
`ifdef MEMARB_ANTISTARVE_EN
        exp_if_rd = ref_mem[11];
`endif
        check("sv_mem_rdata", mem_rdata, exp_mem_rd);
        check("sv_if_rdata", if_rdata, exp_if_rd);

        // Reset in the middle of a store
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 7'd20; mem_wdata = 32'h5555_AAAA;
        tick();
        check("rs_grant", {31'd0, mem_grant}, 32'd1);
        mem_req = 1'b0;
        tick();
        check("rs_wre_active", {31'd0, ram_wre}, 32'd0);
        reset = 1'b0;
        #1;
        exp_if_rd  = 32'd0;
        exp_mem_rd = 32'd0;
        check("rs_wre",       {31'd0, ram_wre}, 32'd1);
        check("rs_addr",      {25'd0, ram_addr}, 32'd0);
        check("rs_wdata",     ram_wdata, 32'd0);
        check("rs_outs",      {28'd0, if_grant, mem_grant, if_valid, mem_valid}, 32'd0);
        check("rs_if_rdata",  if_rdata, exp_if_rd);
        check("rs_mem_rdata", mem_rdata, exp_mem_rd);
        tick();
        tick();
        check("rs_ram_word", ram_mem[20], ref_mem[20]);
        reset = 1'b1;
        tick();
        do_txn(1'b0, 1'b0, 7'd20, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single 128-word instruction/data RAM between two requesters: the fetch stage (read-only) and the memory stage (load/store).
- Sits between both pipeline stages and the Ram instance.
- Serializes accesses and stretches the RAM access over RAM_LAT cycles.
- Generates per-requester stall signals so the pipeline freezes while a requester waits.

Parameters:
- RAM_LAT, 1, cycles the RAM address and strobe are held per access (legal range 1..15).
- ADDR_W, 7, RAM word-address width.
- STARVE_MAX, 3, consecutive lost arbitrations after which fetch wins (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request; held until if_grant.
- if_addr  in  ADDR_W  fetch word address.
- if_grant  out  1  one-cycle pulse: fetch request accepted.
- if_valid  out  1  one-cycle pulse: if_rdata updated.
- if_rdata  out  32  fetched word; held until the next if_valid.
- if_stall  out  1  high when if_req=1 and if_valid=0 (combinational).
- mem_req  in  1  memory-stage request; held until mem_grant.
- mem_we  in  1  1=store, 0=load.
- mem_addr  in  ADDR_W  data word address.
- mem_wdata  in  32  store data.
- mem_grant  out  1  one-cycle pulse: memory request accepted.
- mem_valid  out  1  one-cycle pulse: load data ready, or store complete.
- mem_rdata  out  32  load data; unchanged on store completion.
- mem_stall  out  1  high when mem_req=1 and mem_valid=0 (combinational).
- ram_addr  out  ADDR_W  RAM address.
- ram_wre  out  1  RAM strobe, 1=read, 0=write.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data.

Behaviour:
- States: IDLE and ACCESS. Registers: owner (0=IF, 1=MEM), latched addr/we/wdata, lat_cnt (4 bits).
- Reset (async, any state): state=IDLE, lat_cnt=0, all grants and valids=0, if_rdata=mem_rdata=0, ram_addr=0, ram_wre=1, ram_wdata=0, starvation counter=0.
- An in-flight access is abandoned on reset. No write occurs after reset assertion because ram_wre is forced to 1 asynchronously.
- IDLE: on an edge where any request is high:
  - latch the winner's addr/we/wdata;
  - go to ACCESS;
  - set lat_cnt=RAM_LAT-1;
  - pulse the winner's grant in the following cycle.
- Arbitration when both requests are high: MEM wins (it is the older instruction). IF waits with if_stall=1.
- ACCESS:
  - ram_addr = latched addr.
  - ram_wre = ~latched we for MEM, 1 for IF.
  - ram_wdata = latched wdata.
  - lat_cnt decrements each edge. On the edge with lat_cnt==0: capture ram_rdata into the owner's rdata (loads/fetch only), pulse the owner's valid for one cycle, return to IDLE.
- Latency: grant-cycle to valid-cycle = RAM_LAT edges. Back-to-back throughput is one access per RAM_LAT+1 cycles. A request present on the completing edge is granted on the next edge.
- Outside ACCESS: ram_addr=0, ram_wre=1, ram_wdata=0.
- A request dropped before its grant is cancelled with no RAM activity. Request inputs are ignored during ACCESS.
- A requester whose grant has pulsed does not re-request until it sees its valid. Any new request during ACCESS is sampled only on return to IDLE.
- Same-address store then fetch: the fetch sees the stored value (stores complete before the later grant).

Optional Feature:
- Macro: MEMARB_ANTISTARVE_EN.
- Defined:
  - A 2-bit saturating counter increments on each edge where both requests are high and MEM wins.
  - When the counter equals STARVE_MAX, the next conflict is won by IF.
  - The counter clears on any IF grant and on reset.
- Not defined: the counter is absent and MEM always wins conflicts. IF can starve indefinitely under continuous mem_req.

Test Plan:
1. RAM_LAT=1, RAM[5]=0x1234_5678; if_req=1, if_addr=5 for one edge -> if_grant next cycle, if_valid one cycle later, if_rdata=0x1234_5678; if_stall high until the valid cycle.
2. RAM_LAT=3; mem_req, mem_we=1, addr=9, wdata=0xDEAD_BEEF -> ram_wre=0 for exactly 3 cycles with ram_addr=9; mem_valid pulses; a following IF read of 9 returns 0xDEAD_BEEF.
3. if_req and mem_req both rise the same edge (load addr 2, fetch addr 3) -> mem_grant first, mem_rdata=RAM[2]; then if_grant, if_rdata=RAM[3]; if_stall high throughout the MEM access.
4. Macro on, STARVE_MAX=3, both requests continuously high -> grant order MEM, MEM, MEM, IF, MEM, MEM, MEM, IF. Macro off -> IF never granted.
5. reset low during a RAM_LAT=4 store at cycle 2 -> ram_wre=1 immediately, all outputs at reset values, RAM word unchanged; after release, a fresh if_req is served normally.
